// File: rtl/ahb_mainfsm.sv
// Main control FSM for the multicycle ARM core on AHB. Memory states stretch
// on HREADY low, and a watchdog aborts a transfer that hangs too long.
module ahb_mainfsm #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       HREADY,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       MemReq,
    output logic       InstrDone,
    output logic       BusErr,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          memst, timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        memst   = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
        timeout = (TIMEOUT != 0) && memst && !HREADY && (cnt == CW'(TIMEOUT - 1));
    end

    always_comb begin
        nxt       = cur;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        MemReq    = 1'b0;
        InstrDone = 1'b0;
        BusErr    = 1'b0;
        IllegalOp = 1'b0;
        case (cur)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = HREADY;
                NextPC    = HREADY;
                if (HREADY) nxt = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   nxt = Funct[5] ? EXECI : EXECR;
                    2'b01:   nxt = MEMADR;
                    2'b10:   nxt = BRANCH;
                    default: begin
                        nxt       = FETCH;
                        IllegalOp = 1'b1;
                        InstrDone = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                nxt     = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (HREADY) nxt = MEMWB;
            end
            MEMWR: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = HREADY;
                if (HREADY) nxt = FETCH;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                InstrDone = 1'b1;
                nxt       = FETCH;
            end
            EXECR: begin
                ALUOp = 1'b1;
                nxt   = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                InstrDone = 1'b1;
                nxt       = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // HREADY is low whenever timeout fires, so FETCH's IRWrite/NextPC are already 0
        if (timeout) begin
            nxt    = FETCH;
            BusErr = 1'b1;
        end
        // Reset is asynchronous, so requests must drop combinationally, not on the next edge
        if (!reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            MemReq    = 1'b0;
            InstrDone = 1'b0;
            BusErr    = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    always_comb begin
        if (!memst || HREADY || timeout || (nxt != cur))
            cnt_nxt = '0;
        else if (cnt < CW'(TIMEOUT))
            cnt_nxt = cnt + 1'b1;
        else
            cnt_nxt = cnt;
    end

    assign State = cur;

endmodule

// File: tb/tb_ahb_mainfsm.sv
// Directed bench for ahb_mainfsm (TIMEOUT=4): the driver pushes hand-computed
// per-cycle expectations, and a negedge monitor pops and compares them.
module tb_ahb_mainfsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       HREADY = 1'b1;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
    logic       MemReq, InstrDone, BusErr, IllegalOp;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    ahb_mainfsm #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .HREADY(HREADY),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .MemReq(MemReq), .InstrDone(InstrDone),
        .BusErr(BusErr), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                           MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BR = 4'd9;
    // pulse vector order: IRWrite NextPC RegW MemW Branch MemReq InstrDone BusErr IllegalOp
    localparam logic [8:0] NONE = 9'h000, IRW = 9'h100, NPC = 9'h080, RW = 9'h040,
                           MWB = 9'h020, BRB = 9'h010, MRQ = 9'h008, DN = 9'h004,
                           BE = 9'h002, IL = 9'h001;
    localparam logic [8:0] FET = IRW | NPC | MRQ;

    // expected mux selects {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc} per state
    function automatic logic [6:0] sel_of(input logic [3:0] s);
        case (s)
            F, D:    return 7'b0_1_10_0_10;
            MA:      return 7'b0_0_01_0_00;
            MR, MW:  return 7'b1_0_00_0_00;
            MB:      return 7'b0_0_00_0_01;
            ER:      return 7'b0_0_00_1_00;
            EI:      return 7'b0_0_01_1_00;
            BR:      return 7'b0_0_01_0_10;
            default: return 7'b0;
        endcase
    endfunction

    logic [19:0] expq[$];
    int          tests = 0;
    int          fails = 0;
    int          vec   = 0;

    task automatic step(input logic r, input logic [1:0] op, input logic [5:0] fn,
                        input logic hr, input logic [3:0] st, input logic [8:0] pl);
        @(posedge clk);
        #1;
        reset  = r;
        Op     = op;
        Funct  = fn;
        HREADY = hr;
        expq.push_back({st, pl, sel_of(st)});
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            logic [19:0] e, a;
            e = expq.pop_front();
            a = {State, IRWrite, NextPC, RegW, MemW, Branch, MemReq, InstrDone,
                 BusErr, IllegalOp, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL vec%0d: state/pulses/sels got %h/%b/%b want %h/%b/%b",
                         vec, a[19:16], a[15:7], a[6:0], e[19:16], e[15:7], e[6:0]);
            end
            vec++;
        end
    end

    localparam logic [5:0] ADDR = 6'b001000, ADDI = 6'b101000, LDR = 6'b011001,
                           STR = 6'b011000, BFN = 6'b100000;

    initial begin
        // reset state
        step(0, 2'b00, ADDR, 1, F, NONE);
        step(0, 2'b00, ADDR, 1, F, NONE);
        // ADD register
        step(1, 2'b00, ADDR, 1, F,  FET);
        step(1, 2'b00, ADDR, 1, D,  NONE);
        step(1, 2'b00, ADDR, 1, ER, NONE);
        step(1, 2'b00, ADDR, 1, AW, RW | DN);
        // ADD immediate
        step(1, 2'b00, ADDI, 1, F,  FET);
        step(1, 2'b00, ADDI, 1, D,  NONE);
        step(1, 2'b00, ADDI, 1, EI, NONE);
        step(1, 2'b00, ADDI, 1, AW, RW | DN);
        // LDR with two data wait states
        step(1, 2'b01, LDR, 1, F,  FET);
        step(1, 2'b01, LDR, 1, D,  NONE);
        step(1, 2'b01, LDR, 1, MA, NONE);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 1, MR, MRQ);
        step(1, 2'b01, LDR, 1, MB, RW | DN);
        // STR, zero wait
        step(1, 2'b01, STR, 1, F,  FET);
        step(1, 2'b01, STR, 1, D,  NONE);
        step(1, 2'b01, STR, 1, MA, NONE);
        step(1, 2'b01, STR, 1, MW, MRQ | MWB | DN);
        // Branch
        step(1, 2'b10, BFN, 1, F,  FET);
        step(1, 2'b10, BFN, 1, D,  NONE);
        step(1, 2'b10, BFN, 1, BR, BRB | DN);
        // LDR watchdog: 4th wait cycle aborts
        step(1, 2'b01, LDR, 1, F,  FET);
        step(1, 2'b01, LDR, 1, D,  NONE);
        step(1, 2'b01, LDR, 1, MA, NONE);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ | BE);
        // fetch waits once, then watchdog boundary where HREADY wins
        step(1, 2'b01, LDR, 0, F,  MRQ);
        step(1, 2'b01, LDR, 1, F,  FET);
        step(1, 2'b01, LDR, 1, D,  NONE);
        step(1, 2'b01, LDR, 1, MA, NONE);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 0, MR, MRQ);
        step(1, 2'b01, LDR, 1, MR, MRQ);
        step(1, 2'b01, LDR, 1, MB, RW | DN);
        // fetch watchdog: stays in FETCH with BusErr, no IRWrite
        step(1, 2'b11, 6'b0, 0, F, MRQ);
        step(1, 2'b11, 6'b0, 0, F, MRQ);
        step(1, 2'b11, 6'b0, 0, F, MRQ);
        step(1, 2'b11, 6'b0, 0, F, MRQ | BE);
        // illegal opcode
        step(1, 2'b11, 6'b0, 1, F, FET);
        step(1, 2'b11, 6'b0, 1, D, IL | DN);
        // reset during STR wait, then counter starts from zero
        step(1, 2'b01, STR, 1, F,  FET);
        step(1, 2'b01, STR, 1, D,  NONE);
        step(1, 2'b01, STR, 1, MA, NONE);
        step(1, 2'b01, STR, 0, MW, MRQ | MWB);
        step(0, 2'b01, STR, 0, F,  NONE);
        step(0, 2'b01, STR, 0, F,  NONE);
        step(1, 2'b01, STR, 0, F,  MRQ);
        step(1, 2'b01, STR, 0, F,  MRQ);
        step(1, 2'b01, STR, 0, F,  MRQ);
        step(1, 2'b01, STR, 1, F,  FET);
        step(1, 2'b01, STR, 1, D,  NONE);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
